// File: rtl/reg_file_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : reg_file_pkg                                                 |
// | Description : Shared constants, types and helpers for the 2W2R register    |
// |               file (default geometry, address-width function, write-      |
// |               request struct, zero-register switch).                       |
// | Config      : REG_FILE_ZERO_REG_EN - when defined, register 0 is hardwired |
// |               to zero.                                                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package reg_file_pkg;

    localparam int c_DATA_W_DEFAULT = 16;
    localparam int c_DEPTH_DEFAULT  = 16;

    // The write-request struct is width-independent so that one type serves
    // every parameterisation; instances zero-extend into these fields.
    localparam int c_REQ_ADDR_W = 16;
    localparam int c_REQ_DATA_W = 64;

`ifdef REG_FILE_ZERO_REG_EN
    localparam bit c_ZERO_REG_EN = 1'b1;
`else
    localparam bit c_ZERO_REG_EN = 1'b0;
`endif

    typedef struct packed {
        logic                    en;
        logic [c_REQ_ADDR_W-1:0] addr;
        logic [c_REQ_DATA_W-1:0] data;
    } wr_req_t;

    // A single-entry file still needs a one-bit address port.
    function automatic int reg_file_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file_rd_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : reg_file_rd_port                                             |
// | Description : One registered read port: array mux, range check, two-port  |
// |               write bypass (port 1 wins), zero-register masking, output   |
// |               register that holds while the read enable is low.          |
// | Ports       : clk, rst         - clock, synchronous active-high reset      |
// |               i_regs           - flattened register array                  |
// |               i_wr0, i_wr1     - same-cycle write requests for bypass      |
// |               i_rd_en          - read enable                               |
// |               i_rd_addr        - read address                              |
// |               o_data           - registered read data                      |
// | Config      : REG_FILE_ZERO_REG_EN - reads of address 0 load zero.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int DATA_W = c_DATA_W_DEFAULT,
    parameter int DEPTH  = c_DEPTH_DEFAULT,
    parameter int ADDR_W = reg_file_addr_w(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DEPTH-1:0][DATA_W-1:0] i_regs,
    input  wr_req_t                      i_wr0,
    input  wr_req_t                      i_wr1,
    input  logic                         i_rd_en,
    input  logic [ADDR_W-1:0]            i_rd_addr,
    output logic [DATA_W-1:0]            o_data
);

    logic                    w_rd_in_range;
    logic                    w_rd_ok;
    logic [c_REQ_ADDR_W-1:0] w_rd_addr_x;
    logic                    w_hit0;
    logic                    w_hit1;
    logic [DATA_W-1:0]       w_next;
    logic [DATA_W-1:0]       r_data;

    // Only a non-power-of-two depth has unreachable addresses to reject.
    if (DEPTH < (1 << ADDR_W)) begin : g_partial_range
        assign w_rd_in_range = (i_rd_addr < ADDR_W'(DEPTH));
    end else begin : g_full_range
        assign w_rd_in_range = 1'b1;
    end

    if (DATA_W < c_REQ_DATA_W) begin : g_data_pad
        logic w_unused_pad;
        assign w_unused_pad = ^{i_wr0.data[c_REQ_DATA_W-1:DATA_W],
                                i_wr1.data[c_REQ_DATA_W-1:DATA_W]};
    end

    assign w_rd_ok     = w_rd_in_range && !(c_ZERO_REG_EN && (i_rd_addr == '0));
    assign w_rd_addr_x = c_REQ_ADDR_W'(i_rd_addr);

    // A matching write is necessarily in range and non-zero whenever the read
    // itself passes w_rd_ok, so the write side needs no separate qualification.
    assign w_hit0 = i_wr0.en && (i_wr0.addr == w_rd_addr_x);
    assign w_hit1 = i_wr1.en && (i_wr1.addr == w_rd_addr_x);

    always_comb begin
        w_next = '0;
        if (w_rd_ok) begin
            if (w_hit1) begin
                w_next = i_wr1.data[DATA_W-1:0];
            end else if (w_hit0) begin
                w_next = i_wr0.data[DATA_W-1:0];
            end else begin
                w_next = i_regs[i_rd_addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
        end else if (i_rd_en) begin
            r_data <= w_next;
        end
    end

    assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/reg_file_2w2r.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : reg_file_2w2r                                                |
// | Description : DEPTH x DATA_W register file, two write ports (port 1 has   |
// |               priority), two registered read ports with same-cycle        |
// |               write-to-read bypass.                                        |
// | Ports       : Clk                       - clock                            |
// |               Clear                     - synchronous active-high reset    |
// |               WrEn0/WrAddr0/WrData0     - write port 0                     |
// |               WrEn1/WrAddr1/WrData1     - write port 1 (higher priority)   |
// |               RdEnA/RdAddrA -> DataA    - read port A (1-cycle latency)    |
// |               RdEnB/RdAddrB -> DataB    - read port B (1-cycle latency)    |
// | Config      : REG_FILE_ZERO_REG_EN - register 0 hardwired to zero.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module reg_file_2w2r
    import reg_file_pkg::*;
#(
    parameter  int DATA_W = c_DATA_W_DEFAULT,
    parameter  int DEPTH  = c_DEPTH_DEFAULT,
    localparam int ADDR_W = reg_file_addr_w(DEPTH)
) (
    input  logic              Clk,
    input  logic              Clear,
    input  logic              WrEn0,
    input  logic [ADDR_W-1:0] WrAddr0,
    input  logic [DATA_W-1:0] WrData0,
    input  logic              WrEn1,
    input  logic [ADDR_W-1:0] WrAddr1,
    input  logic [DATA_W-1:0] WrData1,
    input  logic              RdEnA,
    input  logic [ADDR_W-1:0] RdAddrA,
    output logic [DATA_W-1:0] DataA,
    input  logic              RdEnB,
    input  logic [ADDR_W-1:0] RdAddrB,
    output logic [DATA_W-1:0] DataB
);

    logic [DEPTH-1:0][DATA_W-1:0] r_mem;
    logic                         w_wr0_in_range;
    logic                         w_wr1_in_range;
    logic                         w_wr0_ok;
    logic                         w_wr1_ok;
    wr_req_t                      w_req0;
    wr_req_t                      w_req1;

    if (DEPTH < (1 << ADDR_W)) begin : g_partial_range
        assign w_wr0_in_range = (WrAddr0 < ADDR_W'(DEPTH));
        assign w_wr1_in_range = (WrAddr1 < ADDR_W'(DEPTH));
    end else begin : g_full_range
        assign w_wr0_in_range = 1'b1;
        assign w_wr1_in_range = 1'b1;
    end

    assign w_wr0_ok = WrEn0 && w_wr0_in_range && !(c_ZERO_REG_EN && (WrAddr0 == '0));
    assign w_wr1_ok = WrEn1 && w_wr1_in_range && !(c_ZERO_REG_EN && (WrAddr1 == '0));

    // Port 1 is assigned last so it wins an address collision. With the zero
    // register enabled word 0 is never written and stays at its reset value.
    always_ff @(posedge Clk) begin
        if (Clear) begin
            r_mem <= '0;
        end else begin
            if (w_wr0_ok) begin
                r_mem[WrAddr0] <= WrData0;
            end
            if (w_wr1_ok) begin
                r_mem[WrAddr1] <= WrData1;
            end
        end
    end

    // Raw requests go to the read ports; they apply their own range and
    // zero-register masking to the read address.
    always_comb begin
        w_req0                   = '0;
        w_req0.en                = WrEn0;
        w_req0.addr[ADDR_W-1:0]  = WrAddr0;
        w_req0.data[DATA_W-1:0]  = WrData0;
        w_req1                   = '0;
        w_req1.en                = WrEn1;
        w_req1.addr[ADDR_W-1:0]  = WrAddr1;
        w_req1.data[DATA_W-1:0]  = WrData1;
    end

    reg_file_rd_port #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_rd_a (
        .clk       (Clk),
        .rst       (Clear),
        .i_regs    (r_mem),
        .i_wr0     (w_req0),
        .i_wr1     (w_req1),
        .i_rd_en   (RdEnA),
        .i_rd_addr (RdAddrA),
        .o_data    (DataA)
    );

    reg_file_rd_port #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_rd_b (
        .clk       (Clk),
        .rst       (Clear),
        .i_regs    (r_mem),
        .i_wr0     (w_req0),
        .i_wr1     (w_req1),
        .i_rd_en   (RdEnB),
        .i_rd_addr (RdAddrB),
        .o_data    (DataB)
    );

endmodule
`default_nettype wire

// File: tb/tb_reg_file_2w2r.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_reg_file_2w2r                                             |
// | Description : Scoreboard bench for reg_file_2w2r. Two instances (DEPTH 16 |
// |               and DEPTH 12) share one stimulus stream; each expectation   |
// |               carries the value for both depths.                          |
// | Config      : REG_FILE_ZERO_REG_EN - expectations for address 0 become 0. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_reg_file_2w2r;

`ifdef REG_FILE_ZERO_REG_EN
    localparam bit c_ZR = 1'b1;
`else
    localparam bit c_ZR = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [15:0] e16;
        logic [15:0] e12;
    } exp_t;

    logic        clk = 1'b0;
    logic        clear, we0, we1, rea, reb, chka, chkb;
    logic [3:0]  wa0, wa1, raa, rab;
    logic [15:0] wd0, wd1;
    logic [15:0] da16, db16, da12, db12;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    reg_file_2w2r #(.DATA_W(16), .DEPTH(16)) u_dut16 (
        .Clk(clk), .Clear(clear),
        .WrEn0(we0), .WrAddr0(wa0), .WrData0(wd0),
        .WrEn1(we1), .WrAddr1(wa1), .WrData1(wd1),
        .RdEnA(rea), .RdAddrA(raa), .DataA(da16),
        .RdEnB(reb), .RdAddrB(rab), .DataB(db16)
    );

    reg_file_2w2r #(.DATA_W(16), .DEPTH(12)) u_dut12 (
        .Clk(clk), .Clear(clear),
        .WrEn0(we0), .WrAddr0(wa0), .WrData0(wd0),
        .WrEn1(we1), .WrAddr1(wa1), .WrData1(wd1),
        .RdEnA(rea), .RdAddrA(raa), .DataA(da12),
        .RdEnB(reb), .RdAddrB(rab), .DataB(db12)
    );

    function automatic logic [15:0] zr(input int a, input logic [15:0] v);
        return (c_ZR && a == 0) ? 16'h0000 : v;
    endfunction

    function automatic logic [15:0] e12(input int a, input logic [15:0] v);
        return (a >= 12) ? 16'h0000 : zr(a, v);
    endfunction

    task automatic idle();
        clear = 1'b0; we0 = 1'b0; we1 = 1'b0; rea = 1'b0; reb = 1'b0;
        chka = 1'b0; chkb = 1'b0;
        wa0 = 4'd0; wa1 = 4'd0; raa = 4'd0; rab = 4'd0;
        wd0 = 16'h0; wd1 = 16'h0;
    endtask

    task automatic step();
        @(negedge clk);
        idle();
    endtask

    task automatic wr0(input int a, input logic [15:0] d);
        we0 = 1'b1; wa0 = 4'(a); wd0 = d;
    endtask

    task automatic wr1(input int a, input logic [15:0] d);
        we1 = 1'b1; wa1 = 4'(a); wd1 = d;
    endtask

    task automatic holda(input string nm, input logic [15:0] x16, input logic [15:0] x12);
        exp_t t;
        t.name = nm; t.e16 = x16; t.e12 = x12;
        chka = 1'b1;
        qa.push_back(t);
    endtask

    task automatic holdb(input string nm, input logic [15:0] x16, input logic [15:0] x12);
        exp_t t;
        t.name = nm; t.e16 = x16; t.e12 = x12;
        chkb = 1'b1;
        qb.push_back(t);
    endtask

    task automatic rda(input string nm, input int a, input logic [15:0] x16, input logic [15:0] x12);
        rea = 1'b1; raa = 4'(a);
        holda(nm, x16, x12);
    endtask

    task automatic rdb(input string nm, input int a, input logic [15:0] x16, input logic [15:0] x12);
        reb = 1'b1; rab = 4'(a);
        holdb(nm, x16, x12);
    endtask

    task automatic compare(input string port, input exp_t e,
                           input logic [15:0] a16, input logic [15:0] a12);
        checks += 2;
        if (a16 !== e.e16) begin
            errors++;
            $display("FAIL %s_%s depth16: got %h want %h", e.name, port, a16, e.e16);
        end
        if (a12 !== e.e12) begin
            errors++;
            $display("FAIL %s_%s depth12: got %h want %h", e.name, port, a12, e.e12);
        end
    endtask

    // Monitor: an expectation is due one edge after the cycle it was issued in.
    logic fa, fb;
    exp_t ma, mb;
    initial begin
        forever begin
            @(posedge clk);
            fa = chka;
            fb = chkb;
            #1;
            if (fa) begin
                if (qa.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL underflow_A: got empty queue want entry");
                end else begin
                    ma = qa.pop_front();
                    compare("A", ma, da16, da12);
                end
            end
            if (fb) begin
                if (qb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL underflow_B: got empty queue want entry");
                end else begin
                    mb = qb.pop_front();
                    compare("B", mb, db16, db12);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        // Reset state of both output registers.
        clear = 1'b1;
        holda("reset", 16'h0, 16'h0);
        holdb("reset", 16'h0, 16'h0);
        step();

        // Reset wipes a written register; then the output holds.
        wr0(3, 16'd5); step();
        clear = 1'b1; step();
        rda("rst_rd", 3, 16'h0, 16'h0); step();
        holda("hold_zero", 16'h0, 16'h0); step();

        // Basic dual write then dual read.
        wr0(0, 16'd5); wr1(1, 16'd6); step();
        rda("basic0", 0, zr(0, 16'd5), zr(0, 16'd5));
        rdb("basic1", 1, 16'd6, 16'd6);
        step();

        // Fill all 16 addresses with addr+1; depth-12 drops 12..15.
        for (int k = 0; k < 8; k++) begin
            wr0(2 * k, 16'(2 * k + 1));
            wr1(2 * k + 1, 16'(2 * k + 2));
            step();
        end
        for (int k = 0; k < 8; k++) begin
            rda($sformatf("fill%0d", 2 * k), 2 * k,
                zr(2 * k, 16'(2 * k + 1)), e12(2 * k, 16'(2 * k + 1)));
            rdb($sformatf("fill%0d", 2 * k + 1), 2 * k + 1,
                16'(2 * k + 2), e12(2 * k + 1, 16'(2 * k + 2)));
            step();
        end
        holda("hold_a", 16'd15, 16'd0);
        holdb("hold_b", 16'd16, 16'd0);
        step();

        // Write collision: port 1 wins.
        wr0(7, 16'h1111); wr1(7, 16'h2222); step();
        rda("collide", 7, 16'h2222, 16'h2222); step();

        // Bypass from port 0, then from both ports on both readers.
        wr0(9, 16'hBEEF);
        rda("byp0", 9, 16'hBEEF, 16'hBEEF);
        step();
        wr0(9, 16'hAAAA); wr1(9, 16'hBBBB);
        rda("byp01", 9, 16'hBBBB, 16'hBBBB);
        rdb("byp01", 9, 16'hBBBB, 16'hBBBB);
        step();
        rda("byp_commit", 9, 16'hBBBB, 16'hBBBB); step();

        // Clear beats a same-cycle write and read.
        clear = 1'b1; wr0(4, 16'h00FF);
        rda("clr_rd", 5, 16'h0, 16'h0);
        step();
        rda("clr4", 4, 16'h0, 16'h0);
        rdb("clr9", 9, 16'h0, 16'h0);
        step();

        // Out-of-range write on depth 12: ignored, no bypass, no aliasing.
        wr0(1, 16'h0101); wr1(5, 16'h0505); step();
        wr0(13, 16'h5A5A);
        rda("oor_byp", 13, 16'h5A5A, 16'h0);
        step();
        rda("alias1", 1, 16'h0101, 16'h0101);
        rdb("alias5", 5, 16'h0505, 16'h0505);
        step();
        rda("oor_rd", 13, 16'h5A5A, 16'h0); step();

        // Address 0: ordinary register or hardwired zero.
        wr1(0, 16'h1234);
        rdb("zr_byp1", 0, zr(0, 16'h1234), zr(0, 16'h1234));
        step();
        rda("zr_rd", 0, zr(0, 16'h1234), zr(0, 16'h1234)); step();
        wr0(0, 16'h4321);
        rda("zr_byp0", 0, zr(0, 16'h4321), zr(0, 16'h4321));
        step();

        step();
        step();
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending want 0/0", qa.size(), qb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
